// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise the data port wins ties.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int   CNT_W  = $clog2(MEM_LAT + 1);
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_nxt;
   logic              owner;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;
   logic              if_elig, d_elig;
   logic              grant_if, grant_d;
   logic              last_cycle;

   // A port whose done is pulsing is masked so its still-held req is not re-granted.
   assign if_elig    = (state == IDLE) && if_req && !if_done;
   assign d_elig     = (state == IDLE) && d_req  && !d_done;
   assign last_cycle = (state == BUSY) && (cnt == CNT_W'(MEM_LAT - 1));

`ifdef MEM_ARB_RR_EN
   logic last_grant;

   assign grant_d  = d_elig && (!if_elig || (last_grant == OWN_IF));
   assign grant_if = if_elig && !grant_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= OWN_D;
      else if (grant_d || grant_if)
         last_grant <= grant_d ? OWN_D : OWN_IF;
   end
`else
   assign grant_d  = d_elig;
   assign grant_if = if_elig && !d_elig;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_d || grant_if) state_nxt = BUSY;
         BUSY:    if (last_cycle)          state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == BUSY);
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == BUSY) begin
         mem_en    = 1'b1;
         mem_wr    = wr_q;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end
   end

   // Request latch: requester inputs only matter in the grant cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner   <= OWN_IF;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt     <= '0;
      end else if (grant_d || grant_if) begin
         owner   <= grant_d ? OWN_D : OWN_IF;
         wr_q    <= grant_d && d_wr;
         addr_q  <= grant_d ? d_addr : if_addr;
         wdata_q <= grant_d ? d_wdata : '0;
         cnt     <= '0;
      end else if (state == BUSY) begin
         cnt     <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         if_done <= last_cycle && (owner == OWN_IF);
         d_done  <= last_cycle && (owner == OWN_D);
         if (last_cycle && !wr_q) begin
            if (owner == OWN_D)
               d_rdata  <= mem_rdata;
            else
               if_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=4); memory returns A5C3 at 0x0010, else addr^F0F0.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_wr;
   logic [15:0] if_addr, d_addr, d_wdata;
   logic [15:0] if_rdata, d_rdata;
   logic        if_done, d_done;
   logic        mem_en, mem_wr, busy;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb mem_rdata = (mem_addr == 16'h0010) ? 16'hA5C3 : (mem_addr ^ 16'hF0F0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      if_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
      if_addr = 16'h0040; d_addr = 16'h0050; d_wdata = 16'hFFFF;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({if_rdata, d_rdata, if_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs cyc=%0d got if_rd=%h d_rd=%h ifd=%b dd=%b en=%b wr=%b a=%h wd=%h busy=%b want all 0",
                     i, if_rdata, d_rdata, if_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata, busy);
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      rst_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle got busy=%b want 0", busy);
      end
   endtask

   task automatic test_fetch();
      if_addr = 16'h0010; if_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         total++;
         if (c <= 4) begin
            if ({mem_en, mem_wr, mem_addr, busy} !== {1'b1, 1'b0, 16'h0010, 1'b1}) begin
               bad++;
               $display("FAIL fetch_mem cyc=%0d got en=%b wr=%b a=%h busy=%b want 1 0 0010 1",
                        c, mem_en, mem_wr, mem_addr, busy);
            end
         end else begin
            if ({mem_en, mem_wr, mem_addr, mem_wdata, busy} !== '0) begin
               bad++;
               $display("FAIL fetch_idle_mem cyc=%0d got en=%b wr=%b a=%h wd=%h busy=%b want 0",
                        c, mem_en, mem_wr, mem_addr, mem_wdata, busy);
            end
         end
         total++;
         if (if_done !== (c == 5)) begin
            bad++;
            $display("FAIL fetch_done cyc=%0d got %b want %b", c, if_done, (c == 5));
         end
         if (c == 5) begin
            total++;
            if (if_rdata !== 16'hA5C3) begin
               bad++;
               $display("FAIL fetch_rdata got %h want a5c3", if_rdata);
            end
            if_req = 1'b0;
         end
      end
   endtask

   // Both ports request together straight out of reset; each drops req on its done.
   task automatic test_tie();
      logic        first_d;
      logic [15:0] a1, a2;
      if_req = 1'b0; d_req = 1'b0;
      apply_reset();
`ifdef MEM_ARB_RR_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      a1 = first_d ? 16'h0200 : 16'h0030;
      a2 = first_d ? 16'h0030 : 16'h0200;
      if_addr = 16'h0030; d_addr = 16'h0200; d_wr = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         if ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) begin
            total++;
            if ({mem_en, mem_wr, mem_addr} !== {1'b1, 1'b0, (c <= 4) ? a1 : a2}) begin
               bad++;
               $display("FAIL tie_mem cyc=%0d got en=%b wr=%b a=%h want 1 0 %h",
                        c, mem_en, mem_wr, mem_addr, (c <= 4) ? a1 : a2);
            end
         end else begin
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL tie_idle cyc=%0d got busy=%b want 0", c, busy);
            end
         end
         total++;
         if ({d_done, if_done} !== {(c == 5) == first_d && (c == 5 || c == 10) ? 1'b1 : (c == 10 && !first_d),
                                    (c == 5) != first_d && (c == 5 || c == 10) ? 1'b1 : (c == 10 && first_d)}) begin
            bad++;
            $display("FAIL tie_done cyc=%0d got d_done=%b if_done=%b", c, d_done, if_done);
         end
         if (d_done) begin
            total++;
            if (d_rdata !== 16'hF2F0) begin
               bad++;
               $display("FAIL tie_d_rdata got %h want f2f0", d_rdata);
            end
            d_req = 1'b0;
         end
         if (if_done) begin
            total++;
            if (if_rdata !== 16'hF0C0) begin
               bad++;
               $display("FAIL tie_if_rdata got %h want f0c0", if_rdata);
            end
            if_req = 1'b0;
         end
      end
   endtask

   task automatic test_store();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
      for (int c = 1; c <= 5; c++) begin
         tick();
         total++;
         if (c <= 4) begin
            if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0100, 16'h1234}) begin
               bad++;
               $display("FAIL store_mem cyc=%0d got en=%b wr=%b a=%h wd=%h want 1 1 0100 1234",
                        c, mem_en, mem_wr, mem_addr, mem_wdata);
            end
         end else begin
            if ({d_done, d_rdata} !== {1'b1, 16'hF2F0}) begin
               bad++;
               $display("FAIL store_done got d_done=%b d_rdata=%h want 1 f2f0", d_done, d_rdata);
            end
            d_req = 1'b0; d_wr = 1'b0;
         end
      end
      tick();
      total++;
      if ({d_done, busy} !== 2'b00) begin
         bad++;
         $display("FAIL store_after got d_done=%b busy=%b want 0 0", d_done, busy);
      end
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
      tick();
      tick();
      total++;
      if ({busy, mem_en, mem_addr} !== {1'b1, 1'b1, 16'h0300}) begin
         bad++;
         $display("FAIL mid_busy got busy=%b en=%b a=%h want 1 1 0300", busy, mem_en, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, mem_en, mem_addr} !== '0) begin
         bad++;
         $display("FAIL mid_async got busy=%b en=%b a=%h want 0 0 0000", busy, mem_en, mem_addr);
      end
      d_req = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({d_done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL mid_no_done i=%0d got d_done=%b busy=%b want 0 0", i, d_done, busy);
         end
      end
      if_addr = 16'h0020; if_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         total++;
         if (if_done !== (c == 5)) begin
            bad++;
            $display("FAIL mid_fetch_done cyc=%0d got %b want %b", c, if_done, (c == 5));
         end
      end
      total++;
      if (if_rdata !== 16'hF0D0) begin
         bad++;
         $display("FAIL mid_fetch_rdata got %h want f0d0", if_rdata);
      end
      if_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_tie();
      test_store();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got still running want finished");
      $fatal(1, "timeout");
   end

endmodule
